// File: rtl/serial_divider_pkg.sv
// Shared definitions for the serial sign-magnitude divider: FSM state encodings
// and the step-counter width helper.
package serial_divider_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Wide enough to count the 2*mag_w restoring steps.
  function automatic int step_cnt_w(input int mag_w);
    return $clog2(2 * mag_w + 1);
  endfunction

endpackage

// File: rtl/serial_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit and
// subtract the divisor magnitude when the shifted partial remainder is large enough.
module div_step
  import serial_divider_pkg::*;
#(
  parameter int MAG_W = 3
) (
  input  logic [MAG_W-1:0] rem,
  input  logic             din,
  input  logic [MAG_W-1:0] dmag,
  output logic [MAG_W-1:0] rem_next,
  output logic             qbit
);

  logic [MAG_W:0] trial;

  // rem < dmag on entry, so trial - dmag always fits back into MAG_W bits.
  always_comb begin
    trial    = {rem, din};
    qbit     = (trial >= {1'b0, dmag});
    rem_next = qbit ? (trial[MAG_W-1:0] - dmag) : trial[MAG_W-1:0];
  end

endmodule

// File: rtl/serial_divider.sv
// Sequential sign-magnitude restoring divider, one quotient bit per clock.
// Optional SERIAL_DIV_ONE_BYPASS_EN: a divisor magnitude of 1 skips the step loop.
module serial_divider
  import serial_divider_pkg::*;
#(
  parameter int MAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*MAG_W:0] dividend,
  input  logic [MAG_W:0]   divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*MAG_W:0] quotient,
  output logic [MAG_W:0]   remainder,
  output logic             div_by_zero
);

  localparam int N  = 2 * MAG_W;
  localparam int CW = step_cnt_w(MAG_W);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);
`ifdef SERIAL_DIV_ONE_BYPASS_EN
  localparam logic [MAG_W-1:0] MAG_ONE = MAG_W'(1);
`endif

  // Handshakes: a transfer happens on a posedge where valid && ready are both high;
  // the producer holds valid and data until that edge, ready never depends on valid.
  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [N-1:0]     work;
  logic [MAG_W-1:0] rem;
  logic [MAG_W-1:0] dmag;
  logic             qsign;
  logic             nsign;
  logic [MAG_W-1:0] rem_next;
  logic             qbit;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // A zero magnitude never carries a sign.
  function automatic logic [N:0] sm_q(input logic s, input logic [N-1:0] m);
    return {s & (|m), m};
  endfunction

  function automatic logic [MAG_W:0] sm_r(input logic s, input logic [MAG_W-1:0] m);
    return {s & (|m), m};
  endfunction

  div_step #(.MAG_W(MAG_W)) u_step (
    .rem      (rem),
    .din      (work[N-1]),
    .dmag     (dmag),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  // work holds the dividend magnitude; it shifts left each step and the
  // quotient bits fill in from the bottom.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      work        <= '0;
      rem         <= '0;
      dmag        <= '0;
      qsign       <= 1'b0;
      nsign       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            work        <= dividend[N-1:0];
            rem         <= '0;
            cnt         <= '0;
            dmag        <= divisor[MAG_W-1:0];
            qsign       <= dividend[N] ^ divisor[MAG_W];
            nsign       <= dividend[N];
            div_by_zero <= 1'b0;
            if (divisor[MAG_W-1:0] == '0) begin
              state       <= ST_DONE;
              div_by_zero <= 1'b1;
              quotient    <= {1'b0, {N{1'b1}}};
              remainder   <= '0;
            end
`ifdef SERIAL_DIV_ONE_BYPASS_EN
            else if (divisor[MAG_W-1:0] == MAG_ONE) begin
              state     <= ST_DONE;
              quotient  <= sm_q(dividend[N] ^ divisor[MAG_W], dividend[N-1:0]);
              remainder <= '0;
            end
`endif
            else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          work <= {work[N-2:0], qbit};
          rem  <= rem_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            state     <= ST_DONE;
            quotient  <= sm_q(qsign, {work[N-2:0], qbit});
            remainder <= sm_r(nsign, rem_next);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
